// File: rtl/alu_unit.sv
// alu_unit: RV32I integer / branch-compare execution unit fed by the RS.
// When ITER_SHIFT is set, shifts by 2 or more run one bit per cycle.
module alu_unit #(
  parameter int ROB_WIDTH  = 4,
  parameter int ITER_SHIFT = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 task_busy,
  input  logic [3:0]           task_opcode,
  input  logic [31:0]          task_lhs,
  input  logic [31:0]          task_rhs,
  input  logic [ROB_WIDTH-1:0] task_tag,
  output logic                 done,
  output logic [31:0]          value,
  output logic [ROB_WIDTH-1:0] tag
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op;
  logic [4:0] cnt, shamt;
  logic iter_start;
  function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'd0:  alu = a + b;
      4'd1:  alu = a - b;
      4'd2:  alu = a << b[4:0];
      4'd3:  alu = {31'b0, $signed(a) < $signed(b)};
      4'd4:  alu = {31'b0, a < b};
      4'd5:  alu = a ^ b;
      4'd6:  alu = a >> b[4:0];
      4'd7:  alu = $signed(a) >>> b[4:0];
      4'd8:  alu = a | b;
      4'd9:  alu = a & b;
      4'd10: alu = {31'b0, a == b};
      4'd11: alu = {31'b0, a != b};
      4'd12: alu = {31'b0, $signed(a) < $signed(b)};
      4'd13: alu = {31'b0, $signed(a) >= $signed(b)};
      4'd14: alu = {31'b0, a < b};
      4'd15: alu = {31'b0, a >= b};
    endcase
  endfunction
  function automatic logic is_shift(input logic [3:0] f);
    return f == 4'd2 || f == 4'd6 || f == 4'd7;
  endfunction
  assign shamt = task_rhs[4:0];
  assign iter_start = ITER_SHIFT != 0 && is_shift(task_opcode) && shamt > 5'd1;
  assign done = state == DONE;
  always_comb begin
    state_nx = clear_signal || state == DONE ? IDLE
             : state == SHIFT ? (cnt == 5'd1 ? DONE : SHIFT)
             : task_busy ? (iter_start ? SHIFT : DONE)
             : IDLE;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nx;
  end
  // Iterative shifts reuse the ALU with a shift amount of 1 on the working value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      op    <= '0;
      cnt   <= '0;
      value <= '0;
      tag   <= '0;
    end else if (rdy_in) begin
      if (clear_signal) cnt <= '0;
      else if (state == IDLE && task_busy) begin
        op    <= task_opcode;
        tag   <= task_tag;
        value <= alu(task_opcode, task_lhs, iter_start ? 32'd1 : task_rhs);
        cnt   <= iter_start ? shamt - 5'd1 : '0;
      end else if (state == SHIFT) begin
        value <= alu(op, value, 32'd1);
        cnt   <= cnt - 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with a scoreboard of expected value, tag and done cycle.
module tb_alu_unit;
  logic clk_in = 0, rst_in = 1, rdy_in = 1, clear_signal = 0, task_busy = 0;
  logic [3:0] task_opcode = 0, task_tag = 0;
  logic [31:0] task_lhs = 0, task_rhs = 0;
  logic done;
  logic [31:0] value;
  logic [3:0] tag;
  int vectors = 0, miscompares = 0, cyc = 0;
  typedef struct {logic [31:0] v; logic [3:0] t; int c;} exp_t;
  exp_t sb[$];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  alu_unit #(.ROB_WIDTH(4), .ITER_SHIFT(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .task_busy(task_busy), .task_opcode(task_opcode), .task_lhs(task_lhs),
    .task_rhs(task_rhs), .task_tag(task_tag), .done(done), .value(value), .tag(tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done: done=1 at cycle %0d, expected 0 (no task outstanding)", cyc);
        end else begin
          e = sb.pop_front();
          check("value", value, e.v);
          check("tag", {28'b0, tag}, {28'b0, e.t});
          check("done_cycle", cyc, e.c);
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (done !== 1'b1 && n < 64);
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  // Busy is held through the DONE cycle and dropped just after its edge, like the RS.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic [31:0] exp, input int lat, input int stall);
    @(negedge clk_in);
    task_busy = 1; task_opcode = op; task_lhs = a; task_rhs = b; task_tag = t;
    sb.push_back('{exp, t, cyc + lat + stall});
    @(posedge clk_in); #1;
    task_lhs = ~a; task_rhs = b ^ 32'h5A; task_opcode = ~op; task_tag = ~t;
    if (stall > 0) begin
      repeat (2) @(negedge clk_in);
      rdy_in = 0;
      repeat (stall) @(negedge clk_in);
      rdy_in = 1;
    end
    wait_done();
    @(posedge clk_in); #1;
    task_busy = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_value", value, 32'd0);
    check("reset_tag", {28'b0, tag}, 32'd0);
    @(negedge clk_in);
    rst_in = 0;
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd0, 1, 0);
    send(4'd3, 32'h8000_0000, 32'd1, 4'd1, 32'd1, 1, 0);
    send(4'd4, 32'h8000_0000, 32'd1, 4'd2, 32'd0, 1, 0);
    send(4'd15, 32'd5, 32'd5, 4'd4, 32'd1, 1, 0);
    send(4'd11, 32'd5, 32'd5, 4'd5, 32'd0, 1, 0);
    send(4'd1, 32'd0, 32'd1, 4'd6, 32'hFFFF_FFFF, 1, 0);
    send(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd8, 32'h0FF0_0FF0, 1, 0);
    send(4'd8, 32'hF0F0_F0F0, 32'h0F0F_0000, 4'd9, 32'hFFFF_F0F0, 1, 0);
    send(4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd10, 32'hF000_F000, 1, 0);
    send(4'd10, 32'd7, 32'd7, 4'd11, 32'd1, 1, 0);
    send(4'd12, 32'hFFFF_FFFF, 32'd0, 4'd12, 32'd1, 1, 0);
    send(4'd13, 32'hFFFF_FFFF, 32'd0, 4'd13, 32'd0, 1, 0);
    send(4'd14, 32'hFFFF_FFFF, 32'd0, 4'd14, 32'd0, 1, 0);
    send(4'd7, 32'h8000_0000, 32'h24, 4'd7, 32'hF800_0000, 4, 0);
    send(4'd2, 32'h1234_5678, 32'h20, 4'd2, 32'h1234_5678, 1, 0);
    send(4'd2, 32'd1, 32'h21, 4'd3, 32'd2, 1, 0);
    send(4'd6, 32'h1234_5678, 32'd8, 4'd4, 32'h0012_3456, 8, 3);
    send(4'd6, 32'h8000_0000, 32'd2, 4'd7, 32'h2000_0000, 2, 0);
    send(4'd2, 32'd1, 32'h1F, 4'd5, 32'h8000_0000, 31, 0);
    send(4'd7, 32'h8000_0000, 32'h1F, 4'd6, 32'hFFFF_FFFF, 31, 0);
    // flush mid-shift while an ADD is already presented: neither may complete
    @(negedge clk_in);
    task_busy = 1; task_opcode = 4'd2; task_lhs = 32'd1; task_rhs = 32'd20; task_tag = 4'd9;
    repeat (4) @(negedge clk_in);
    clear_signal = 1; task_opcode = 4'd0; task_lhs = 32'd2; task_rhs = 32'd3;
    @(negedge clk_in);
    clear_signal = 0; task_busy = 0;
    check("clear_done", {31'b0, done}, 32'd0);
    repeat (30) @(negedge clk_in);
    send(4'd0, 32'd2, 32'd3, 4'd1, 32'd5, 1, 0);
    send(4'd0, 32'd10, 32'd20, 4'd2, 32'd30, 1, 0);
    @(negedge clk_in);
    send(4'd1, 32'd10, 32'd3, 4'd3, 32'd7, 1, 0);
    // async reset pulse during the DONE cycle
    @(negedge clk_in);
    task_busy = 1; task_opcode = 4'd0; task_lhs = 32'd1; task_rhs = 32'd1; task_tag = 4'd5;
    sb.push_back('{32'd2, 4'd5, cyc + 1});
    @(negedge clk_in);
    #2 rst_in = 1; task_busy = 0;
    #1 check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_value", value, 32'd0);
    #1 rst_in = 0;
    // async reset mid-shift abandons the task without a done pulse
    @(negedge clk_in);
    task_busy = 1; task_opcode = 4'd6; task_lhs = 32'hFFFF_0000; task_rhs = 32'd20; task_tag = 4'd1;
    repeat (4) @(negedge clk_in);
    #2 rst_in = 1; task_busy = 0;
    #1 check("shift_rst_done", {31'b0, done}, 32'd0);
    #1 rst_in = 0;
    repeat (30) @(negedge clk_in);
    send(4'd0, 32'd100, 32'd200, 4'd15, 32'd300, 1, 0);
    repeat (3) @(negedge clk_in);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
